// File: rtl/csr_file_pkg.sv
// Shared CSR constants, register-state payload and read-mux helper for csr_file.
// Consumed by csr_file and by the trap controller.
package csr_file_pkg;

  localparam int unsigned CSR_XLEN = 32;
  localparam int unsigned CSR_ADDR_W = 12;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam logic [2:0] CSR_OP_RW  = 3'b001;
  localparam logic [2:0] CSR_OP_RS  = 3'b010;
  localparam logic [2:0] CSR_OP_RC  = 3'b011;
  localparam logic [2:0] CSR_OP_RWI = 3'b101;
  localparam logic [2:0] CSR_OP_RSI = 3'b110;
  localparam logic [2:0] CSR_OP_RCI = 3'b111;

  localparam int unsigned MSTATUS_MIE_BIT  = 3;
  localparam int unsigned MSTATUS_MPIE_BIT = 7;
  localparam int unsigned MSTATUS_MPP_LO   = 11;
  localparam int unsigned MSTATUS_MPP_HI   = 12;

  typedef struct packed {
    logic        mstatus_mie;
    logic        mstatus_mpie;
    logic [31:0] mie;
    logic [31:0] mtvec;
    logic [31:0] mscratch;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [31:0] mtval;
    logic [63:0] mcycle;
    logic [63:0] minstret;
  } csr_state_t;

  function automatic logic csr_is_counter(input logic [11:0] a);
    case (a)
      CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH,
      CSR_CYCLE, CSR_CYCLEH, CSR_INSTRET, CSR_INSTRETH: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic csr_implemented(input logic [11:0] a);
    case (a)
      CSR_MSTATUS, CSR_MISA, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC,
      CSR_MCAUSE, CSR_MTVAL, CSR_MIP, CSR_MVENDORID, CSR_MARCHID,
      CSR_MIMPID, CSR_MHARTID: return 1'b1;
      default: return csr_is_counter(a);
    endcase
  endfunction

  function automatic logic [31:0] csr_read(input csr_state_t s, input logic [11:0] a,
                                           input logic [31:0] misa, input logic [31:0] hartid);
    logic [31:0] r;
    r = '0;
    case (a)
      CSR_MSTATUS: begin
        r[MSTATUS_MIE_BIT]                 = s.mstatus_mie;
        r[MSTATUS_MPIE_BIT]                = s.mstatus_mpie;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO]   = 2'b11;
      end
      CSR_MISA:                  r = misa;
      CSR_MIE:                   r = s.mie;
      CSR_MTVEC:                 r = s.mtvec;
      CSR_MSCRATCH:              r = s.mscratch;
      CSR_MEPC:                  r = s.mepc;
      CSR_MCAUSE:                r = s.mcause;
      CSR_MTVAL:                 r = s.mtval;
      CSR_MCYCLE,   CSR_CYCLE:   r = s.mcycle[31:0];
      CSR_MCYCLEH,  CSR_CYCLEH:  r = s.mcycle[63:32];
      CSR_MINSTRET, CSR_INSTRET: r = s.minstret[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: r = s.minstret[63:32];
      CSR_MHARTID:               r = hartid;
      default:                   r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/csr_file_if.sv
// CSR access bundle: trap-controller port, Zicsr instruction port and retire strobe.
interface csr_file_if #(parameter int unsigned XLEN = 32);
  logic            trap_write_enable;
  logic [11:0]     trap_address;
  logic [XLEN-1:0] trap_write_data;
  logic [XLEN-1:0] trap_read_data;
  logic            instr_csr_enable;
  logic [2:0]      instr_csr_op;
  logic [11:0]     instr_csr_address;
  logic [XLEN-1:0] instr_csr_src;
  logic            instr_csr_rs1_zero;
  logic [XLEN-1:0] instr_read_data;
  logic            illegal_csr;
  logic            instr_retired;

  modport slave (
    input  trap_write_enable, trap_address, trap_write_data,
    input  instr_csr_enable, instr_csr_op, instr_csr_address, instr_csr_src,
    input  instr_csr_rs1_zero, instr_retired,
    output trap_read_data, instr_read_data, illegal_csr
  );

  modport master (
    output trap_write_enable, trap_address, trap_write_data,
    output instr_csr_enable, instr_csr_op, instr_csr_address, instr_csr_src,
    output instr_csr_rs1_zero, instr_retired,
    input  trap_read_data, instr_read_data, illegal_csr
  );
endinterface

// File: rtl/csr_counter64.sv
// 64-bit wrapping counter with half-word overwrite; present only with CSR_COUNTERS_EN.
// A half write replaces that half and suppresses the increment for the cycle.
`ifdef CSR_COUNTERS_EN
module csr_counter64 (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] count
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      count         <= '0;
    else if (wr_lo) count[31:0]   <= wdata;
    else if (wr_hi) count[63:32]  <= wdata;
    else if (inc)   count         <= count + 64'd1;
  end
endmodule
`endif

// File: rtl/csr_file.sv
// Machine-mode CSR file for the RV32I core (trap port + Zicsr port, 0-cycle reads).
// Macro CSR_COUNTERS_EN enables the mcycle/minstret counters and their shadows.
module csr_file
  import csr_file_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter logic [31:0] MHARTID     = 32'd0,
  parameter logic [31:0] MISA_VALUE  = 32'h4000_0100,
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
  input logic       clk,
  input logic       reset,
  csr_file_if.slave bus
);

`ifdef CSR_COUNTERS_EN
  localparam bit COUNTERS_EN = 1'b1;
`else
  localparam bit COUNTERS_EN = 1'b0;
`endif

  logic        mstatus_mie, mstatus_mpie;
  logic [31:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic [63:0] mcycle, minstret;
  csr_state_t  st;

  logic        set_clr, would_write, op_valid, ro_fault, illegal;
  logic        instr_we, wr_en;
  logic [11:0] wr_addr;
  logic [31:0] old_val, instr_wdata, wr_data;

  assign st = '{mstatus_mie: mstatus_mie, mstatus_mpie: mstatus_mpie, mie: mie_q,
                mtvec: mtvec_q, mscratch: mscratch_q, mepc: mepc_q, mcause: mcause_q,
                mtval: mtval_q, mcycle: mcycle, minstret: minstret};

  assign bus.trap_read_data  = csr_read(st, bus.trap_address, MISA_VALUE, MHARTID);
  assign old_val             = csr_read(st, bus.instr_csr_address, MISA_VALUE, MHARTID);
  assign bus.instr_read_data = old_val;

  // Set/clear forms with a zero source neither write nor fault on read-only space.
  always_comb begin
    set_clr     = bus.instr_csr_op[1];
    would_write = !(set_clr && bus.instr_csr_rs1_zero);
    op_valid    = (bus.instr_csr_op[1:0] != 2'b00);
    ro_fault    = (bus.instr_csr_address[11:10] == 2'b11) && would_write &&
                  (COUNTERS_EN || !csr_is_counter(bus.instr_csr_address));
    illegal     = bus.instr_csr_enable &&
                  (!csr_implemented(bus.instr_csr_address) || ro_fault || !op_valid);
    case (bus.instr_csr_op[1:0])
      2'b01:   instr_wdata = bus.instr_csr_src;
      2'b10:   instr_wdata = old_val | bus.instr_csr_src;
      default: instr_wdata = old_val & ~bus.instr_csr_src;
    endcase
    // Trap writes take the single write slot; a colliding instruction write is dropped.
    instr_we = bus.instr_csr_enable && !illegal && would_write && !bus.trap_write_enable;
    wr_en    = bus.trap_write_enable || instr_we;
    wr_addr  = bus.trap_write_enable ? bus.trap_address    : bus.instr_csr_address;
    wr_data  = bus.trap_write_enable ? bus.trap_write_data : instr_wdata;
  end

  assign bus.illegal_csr = illegal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_q        <= '0;
      mtvec_q      <= {RESET_MTVEC[31:2], 2'b00};
      mscratch_q   <= '0;
      mepc_q       <= '0;
      mcause_q     <= '0;
      mtval_q      <= '0;
    end else if (wr_en) begin
      case (wr_addr)
        CSR_MSTATUS: begin
          mstatus_mie  <= wr_data[MSTATUS_MIE_BIT];
          mstatus_mpie <= wr_data[MSTATUS_MPIE_BIT];
        end
        CSR_MIE:      mie_q      <= wr_data;
        CSR_MTVEC:    mtvec_q    <= {wr_data[31:2], 2'b00};
        CSR_MSCRATCH: mscratch_q <= wr_data;
        CSR_MEPC:     mepc_q     <= {wr_data[31:2], 2'b00};
        CSR_MCAUSE:   mcause_q   <= wr_data;
        CSR_MTVAL:    mtval_q    <= wr_data;
        default: ;
      endcase
    end
  end

`ifdef CSR_COUNTERS_EN
  csr_counter64 u_mcycle (
    .clk   (clk),
    .reset (reset),
    .inc   (1'b1),
    .wr_lo (wr_en && (wr_addr == CSR_MCYCLE)),
    .wr_hi (wr_en && (wr_addr == CSR_MCYCLEH)),
    .wdata (wr_data),
    .count (mcycle)
  );

  csr_counter64 u_minstret (
    .clk   (clk),
    .reset (reset),
    .inc   (bus.instr_retired),
    .wr_lo (wr_en && (wr_addr == CSR_MINSTRET)),
    .wr_hi (wr_en && (wr_addr == CSR_MINSTRETH)),
    .wdata (wr_data),
    .count (minstret)
  );
`else
  logic unused_retired;
  assign unused_retired = bus.instr_retired;
  assign mcycle         = '0;
  assign minstret       = '0;
`endif

endmodule

// File: tb/tb_csr_file.sv
// Directed self-checking bench for csr_file; expectations follow CSR_COUNTERS_EN.
module tb_csr_file;
  import csr_file_pkg::*;

`ifdef CSR_COUNTERS_EN
  localparam bit CNT = 1'b1;
`else
  localparam bit CNT = 1'b0;
`endif

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  csr_file_if #(.XLEN(32)) bus ();

  csr_file #(
    .XLEN(32), .MHARTID(32'd0), .MISA_VALUE(32'h4000_0100), .RESET_MTVEC(32'h0000_0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.trap_write_enable  = 1'b0;
    bus.trap_address       = 12'h000;
    bus.trap_write_data    = '0;
    bus.instr_csr_enable   = 1'b0;
    bus.instr_csr_op       = 3'b000;
    bus.instr_csr_address  = 12'h000;
    bus.instr_csr_src      = '0;
    bus.instr_csr_rs1_zero = 1'b0;
    bus.instr_retired      = 1'b0;
  endtask

  task automatic trap_wr(input logic [11:0] a, input logic [31:0] d);
    bus.trap_write_enable = 1'b1;
    bus.trap_address      = a;
    bus.trap_write_data   = d;
  endtask

  task automatic instr(input logic [2:0] op, input logic [11:0] a, input logic [31:0] src,
                       input logic rs1z);
    bus.instr_csr_enable   = 1'b1;
    bus.instr_csr_op       = op;
    bus.instr_csr_address  = a;
    bus.instr_csr_src      = src;
    bus.instr_csr_rs1_zero = rs1z;
  endtask

  task automatic test_reset();
    logic [11:0] addrs [5];
    logic [31:0] exps  [5];
    addrs = '{12'h305, 12'h300, 12'h301, 12'hF14, 12'h341};
    exps  = '{32'h0000_0000, 32'h0000_1800, 32'h4000_0100, 32'h0, 32'h0};
    for (int i = 0; i < 5; i++) begin
      bus.trap_address = addrs[i];
      #1;
      vectors++;
      if (bus.trap_read_data !== exps[i]) begin
        miscompares++;
        $display("FAIL reset_read[%h] got %h exp %h", addrs[i], bus.trap_read_data, exps[i]);
      end
    end
  endtask

  task automatic test_trap_priority();
    trap_wr(CSR_MEPC, 32'h0000_1236);
    instr(CSR_OP_RW, CSR_MSCRATCH, 32'h0000_00AA, 1'b0);
    #1;
    vectors++;
    if (bus.trap_read_data !== 32'h0 || bus.instr_read_data !== 32'h0) begin
      miscompares++;
      $display("FAIL same_cycle_old trap %h instr %h exp 0 0", bus.trap_read_data,
               bus.instr_read_data);
    end
    step();
    idle();
    bus.trap_address      = CSR_MEPC;
    bus.instr_csr_address = CSR_MSCRATCH;
    #1;
    vectors++;
    if (bus.trap_read_data !== 32'h0000_1234) begin
      miscompares++;
      $display("FAIL mepc_mask got %h exp 00001234", bus.trap_read_data);
    end
    vectors++;
    if (bus.instr_read_data !== 32'h0) begin
      miscompares++;
      $display("FAIL collision_drop mscratch got %h exp 0", bus.instr_read_data);
    end
  endtask

  task automatic test_set_clear();
    instr(CSR_OP_RS, CSR_MIE, 32'h8, 1'b0);
    #1;
    vectors++;
    if (bus.instr_read_data !== 32'h0) begin
      miscompares++;
      $display("FAIL csrrs_old got %h exp 0", bus.instr_read_data);
    end
    step();
    instr(CSR_OP_RC, CSR_MIE, 32'h8, 1'b0);
    #1;
    vectors++;
    if (bus.instr_read_data !== 32'h8) begin
      miscompares++;
      $display("FAIL csrrc_old got %h exp 8", bus.instr_read_data);
    end
    step();
    idle();
    trap_wr(CSR_MIE, 32'h5);
    step();
    idle();
    instr(CSR_OP_RS, CSR_MIE, 32'hFF, 1'b1);
    #1;
    vectors++;
    if (bus.instr_read_data !== 32'h5 || bus.illegal_csr !== 1'b0) begin
      miscompares++;
      $display("FAIL rs_zero_read got %h ill %b exp 5 0", bus.instr_read_data, bus.illegal_csr);
    end
    step();
    idle();
    bus.trap_address = CSR_MIE;
    #1;
    vectors++;
    if (bus.trap_read_data !== 32'h5) begin
      miscompares++;
      $display("FAIL rs_zero_nowrite mie got %h exp 5", bus.trap_read_data);
    end
  endtask

  task automatic test_masking();
    instr(CSR_OP_RW, CSR_MSTATUS, 32'hFFFF_FFFF, 1'b0);
    step();
    trap_wr(CSR_MTVEC, 32'h0000_0103);
    instr(CSR_OP_RWI, CSR_MTVAL, 32'h1F, 1'b0);
    step();
    idle();
    bus.trap_address      = CSR_MSTATUS;
    bus.instr_csr_address = CSR_MTVEC;
    #1;
    vectors++;
    if (bus.trap_read_data !== 32'h0000_1888) begin
      miscompares++;
      $display("FAIL mstatus_mask got %h exp 00001888", bus.trap_read_data);
    end
    vectors++;
    if (bus.instr_read_data !== 32'h0000_0100) begin
      miscompares++;
      $display("FAIL mtvec_mask got %h exp 00000100", bus.instr_read_data);
    end
    bus.trap_address = CSR_MTVAL;
    #1;
    vectors++;
    if (bus.trap_read_data !== 32'h0) begin
      miscompares++;
      $display("FAIL mtval_dropped got %h exp 0", bus.trap_read_data);
    end
  endtask

  task automatic test_illegal();
    logic [2:0]  ops   [5];
    logic [11:0] adrs  [5];
    logic        rz    [5];
    logic        exps  [5];
    ops  = '{CSR_OP_RW, 3'b000,       3'b100,       CSR_OP_RW, CSR_OP_RS};
    adrs = '{CSR_MHARTID, CSR_MSCRATCH, CSR_MSCRATCH, 12'h7C0,   CSR_MHARTID};
    rz   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    exps = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      instr(ops[i], adrs[i], 32'h77, rz[i]);
      #1;
      vectors++;
      if (bus.illegal_csr !== exps[i]) begin
        miscompares++;
        $display("FAIL illegal[%0d] op %b addr %h got %b exp %b", i, ops[i], adrs[i],
                 bus.illegal_csr, exps[i]);
      end
      step();
    end
    idle();
    bus.instr_csr_address = 12'h7C0;
    bus.trap_address      = CSR_MSCRATCH;
    #1;
    vectors++;
    if (bus.illegal_csr !== 1'b0 || bus.trap_read_data !== 32'h0) begin
      miscompares++;
      $display("FAIL illegal_nostate ill %b mscratch %h exp 0 0", bus.illegal_csr,
               bus.trap_read_data);
    end
  endtask

  task automatic test_counters();
    trap_wr(CSR_MCYCLE, 32'hFFFF_FFFF);
    step();
    trap_wr(CSR_MCYCLEH, 32'hFFFF_FFFF);
    step();
    idle();
    bus.trap_address      = CSR_MCYCLE;
    bus.instr_csr_address = CSR_MCYCLEH;
    #1;
    vectors++;
    if (bus.trap_read_data !== (CNT ? 32'hFFFF_FFFF : 32'h0) ||
        bus.instr_read_data !== (CNT ? 32'hFFFF_FFFF : 32'h0)) begin
      miscompares++;
      $display("FAIL mcycle_max lo %h hi %h", bus.trap_read_data, bus.instr_read_data);
    end
    step();
    vectors++;
    if (bus.trap_read_data !== 32'h0 || bus.instr_read_data !== 32'h0) begin
      miscompares++;
      $display("FAIL mcycle_wrap lo %h hi %h exp 0 0", bus.trap_read_data, bus.instr_read_data);
    end
    trap_wr(CSR_MCYCLE, 32'h5);
    step();
    trap_wr(CSR_MCYCLEH, 32'h0);
    step();
    idle();
    instr(CSR_OP_RS, CSR_CYCLE, 32'h0, 1'b1);
    #1;
    vectors++;
    if (bus.illegal_csr !== 1'b0 || bus.instr_read_data !== (CNT ? 32'h5 : 32'h0)) begin
      miscompares++;
      $display("FAIL cycle_shadow ill %b got %h exp 0 %h", bus.illegal_csr, bus.instr_read_data,
               (CNT ? 32'h5 : 32'h0));
    end
    if (CNT) begin
      instr(CSR_OP_RW, CSR_CYCLE, 32'h0, 1'b0);
      #1;
      vectors++;
      if (bus.illegal_csr !== 1'b1) begin
        miscompares++;
        $display("FAIL cycle_ro_write ill got %b exp 1", bus.illegal_csr);
      end
    end
    step();
    idle();
    trap_wr(CSR_MINSTRET, 32'h10);
    bus.instr_retired = 1'b1;
    step();
    bus.trap_write_enable = 1'b0;
    step();
    step();
    idle();
    bus.trap_address = CSR_INSTRET;
    #1;
    vectors++;
    if (bus.trap_read_data !== (CNT ? 32'h12 : 32'h0)) begin
      miscompares++;
      $display("FAIL minstret got %h exp %h", bus.trap_read_data, (CNT ? 32'h12 : 32'h0));
    end
  endtask

  task automatic test_reset_mid();
    trap_wr(CSR_MSCRATCH, 32'h55);
    step();
    idle();
    instr(CSR_OP_RW, CSR_MSCRATCH, 32'h99, 1'b0);
    #1;
    vectors++;
    if (bus.instr_read_data !== 32'h55) begin
      miscompares++;
      $display("FAIL mscratch_written got %h exp 55", bus.instr_read_data);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (bus.instr_read_data !== 32'h0) begin
      miscompares++;
      $display("FAIL async_reset mscratch got %h exp 0", bus.instr_read_data);
    end
    step();
    reset = 1'b0;
    idle();
    bus.trap_address      = CSR_MEPC;
    bus.instr_csr_address = CSR_MSTATUS;
    #1;
    vectors++;
    if (bus.trap_read_data !== 32'h0 || bus.instr_read_data !== 32'h0000_1800) begin
      miscompares++;
      $display("FAIL post_reset mepc %h mstatus %h exp 0 1800", bus.trap_read_data,
               bus.instr_read_data);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    idle();
    #12;
    @(negedge clk);
    reset = 1'b0;
    test_reset();
    step();
    test_trap_priority();
    step();
    test_set_clear();
    test_masking();
    test_illegal();
    test_counters();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
